// File: rtl/read_master_if.sv
// Bus bundle for read_master: DDR3 read master, CSR slave and sample stream.
// The master modport is the read_master view; slave is the environment view.
interface read_master_if;
    // DDR3 Avalon-MM read master
    logic               ddr_waitrequest;
    logic [31:0]        ddr_addr;
    logic               ddr_read;
    logic signed [15:0] ddr_readdata;
    logic               ddr_readdatavalid;
    // CSR Avalon-MM slave
    logic [31:0]        writedata;
    logic [31:0]        readdata;
    logic [2:0]         addr;
    logic               read;
    logic               write;
    // Sample stream
    logic signed [15:0] d_out;
    logic               v;
    logic               ready;

    modport master (
        input  ddr_waitrequest, ddr_readdata, ddr_readdatavalid,
        input  writedata, addr, read, write, ready,
        output ddr_addr, ddr_read, readdata, d_out, v
    );

    modport slave (
        output ddr_waitrequest, ddr_readdata, ddr_readdatavalid,
        output writedata, addr, read, write, ready,
        input  ddr_addr, ddr_read, readdata, d_out, v
    );
endinterface

// File: rtl/read_master.sv
// Streaming DDR3 reader: issues pipelined Avalon-MM reads from base with a
// programmable step, buffers returned samples in a FIFO and streams them out.
// Outstanding reads plus buffered samples never exceed FIFO_DEPTH, so the
// FIFO cannot overflow. FIFO_DEPTH must be a power of 2 and at least 2.
module read_master #(
    parameter int MAX_PENDING = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic          clk,
    input  logic          rst,
    read_master_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAXP_W  = CW'(MAX_PENDING);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state;
    logic [31:0]   base_r, len_r, step_r;
    logic [31:0]   run_len, run_step;
    logic [31:0]   issued, delivered;
    logic [31:0]   ddr_addr_r, readdata_r;
    logic          ddr_read_r, done_r;
    logic [CW-1:0] pending, fifo_count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [15:0]   mem [FIFO_DEPTH];

    logic          start_stb, srst_stb;
    logic          accept, push, pop, fifo_empty, room_ok;
    logic [31:0]   issued_nxt;
    logic [CW-1:0] pending_nxt, count_nxt;

    assign start_stb  = bus.write && (bus.addr == 3'd4);
    assign srst_stb   = bus.write && (bus.addr == 3'd6);
    assign accept     = ddr_read_r && !bus.ddr_waitrequest;
    // Returns that land while idle belong to an aborted run and are dropped.
    assign push       = bus.ddr_readdatavalid && (state != IDLE) && !srst_stb;
    assign fifo_empty = (fifo_count == '0);
    assign pop        = !fifo_empty && bus.ready;

    assign issued_nxt  = issued + (accept ? 32'd1 : 32'd0);
    assign pending_nxt = pending + CW'(accept) - CW'(bus.ddr_readdatavalid);
    assign count_nxt   = fifo_count + CW'(push) - CW'(pop);
    // Next-cycle credit: every outstanding read must have a FIFO slot reserved.
    assign room_ok = (({1'b0, pending_nxt} + {1'b0, count_nxt}) < DEPTH_W) &&
                     (pending_nxt < MAXP_W);

    assign bus.ddr_addr = ddr_addr_r;
    assign bus.ddr_read = ddr_read_r;
    assign bus.readdata = readdata_r;
    assign bus.v        = !fifo_empty;
    assign bus.d_out    = fifo_empty ? 16'sd0 : $signed(mem[rd_ptr]);

    // Config registers; a write mid-run only affects the next start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_r <= '0;
            len_r  <= '0;
            step_r <= 32'd1;
        end else if (bus.write) begin
            case (bus.addr)
                3'd0:    base_r <= bus.writedata;
                3'd1:    len_r  <= bus.writedata;
                3'd2:    step_r <= bus.writedata;
                default: ;
            endcase
        end
    end

    // Registered CSR read mux, one cycle after the read strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readdata_r <= '0;
        end else if (bus.read) begin
            case (bus.addr)
                3'd0:    readdata_r <= base_r;
                3'd1:    readdata_r <= len_r;
                3'd2:    readdata_r <= step_r;
                3'd3:    readdata_r <= delivered;
                3'd5:    readdata_r <= {31'd0, done_r};
                default: readdata_r <= 32'hdead_beef;
            endcase
        end
    end

    // Outstanding-read counter; keeps counting through a soft reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending <= '0;
        else      pending <= pending_nxt;
    end

    // FIFO pointers, occupancy and delivered count; soft reset flushes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            delivered  <= '0;
        end else if (srst_stb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            delivered  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                delivered <= delivered + 32'd1;
            end
            fifo_count <= count_nxt;
        end
    end

    // FIFO storage; contents are don't-care until written, d_out is masked when empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.ddr_readdata;
    end

    // Run control FSM with registered ddr_read/ddr_addr/done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ddr_read_r <= 1'b0;
            ddr_addr_r <= '0;
            issued     <= '0;
            run_len    <= '0;
            run_step   <= '0;
            done_r     <= 1'b0;
        end else if (srst_stb) begin
            state      <= IDLE;
            ddr_read_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // Late returns from an aborted run must drain before a restart.
                    if (start_stb && pending == '0) begin
                        ddr_addr_r <= base_r;
                        issued     <= '0;
                        run_len    <= len_r;
                        run_step   <= step_r;
                        if (len_r == 32'd0) begin
                            state      <= DONE;
                            done_r     <= 1'b1;
                            ddr_read_r <= 1'b0;
                        end else begin
                            // FIFO is empty and nothing is pending here.
                            state      <= ISSUE;
                            done_r     <= 1'b0;
                            ddr_read_r <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        ddr_addr_r <= ddr_addr_r + run_step;
                        issued     <= issued_nxt;
                    end
                    if (issued_nxt >= run_len) begin
                        ddr_read_r <= 1'b0;
                        state      <= DRAIN;
                    end else if (ddr_read_r && bus.ddr_waitrequest) begin
                        ddr_read_r <= 1'b1;
                    end else begin
                        ddr_read_r <= room_ok;
                    end
                end
                DRAIN: begin
                    if (pending == '0 && fifo_empty) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_read_master.sv
// Directed bench for read_master: DDR3 responder model with configurable
// latency and waitrequest stall, stream sink log, CSR access tasks.
module tb_read_master;
    localparam int MAXP  = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    read_master_if bus();

    read_master #(.MAX_PENDING(MAXP), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct packed { logic [31:0] a; int due; } req_t;

    req_t        rq[$];
    logic [31:0] acc_addr[$];
    logic [15:0] got[$];
    int cyc = 0;
    int lat = 2;
    int stall_at = 0, stall_len = 0, stall_req = 0, stall_ack = 0, stall_left = 0;
    int a0 = 0, g0 = 0;
    int checks = 0, errors = 0;

    // Memory contents: 0x1111 * (addr[3:0] + 1), so base 0x100 yields 0x1111..0x4444
    function automatic logic [15:0] mem_f(input logic [31:0] a);
        logic [15:0] k;
        k = {12'd0, a[3:0]} + 16'd1;
        return k * 16'h1111;
    endfunction

    // Posedge: log accepted requests and popped samples. Negedge: drive DDR returns/stall.
    always @(posedge clk or negedge clk) begin
        if (clk) begin
            cyc++;
            if (rst) begin
                if (bus.ddr_read && !bus.ddr_waitrequest) begin
                    rq.push_back('{a: bus.ddr_addr, due: cyc + lat});
                    acc_addr.push_back(bus.ddr_addr);
                end
                if (bus.v && bus.ready) got.push_back(bus.d_out);
            end
        end else if (!rst) begin
            rq.delete();
            bus.ddr_readdatavalid = 1'b0;
            bus.ddr_readdata      = '0;
            bus.ddr_waitrequest   = 1'b0;
            stall_left = 0;
        end else begin
            if (rq.size() > 0 && rq[0].due <= cyc + 1) begin
                bus.ddr_readdatavalid = 1'b1;
                bus.ddr_readdata      = mem_f(rq[0].a);
                void'(rq.pop_front());
            end else begin
                bus.ddr_readdatavalid = 1'b0;
            end
            if (stall_left > 0) begin
                bus.ddr_waitrequest = 1'b1;
                stall_left--;
            end else if (stall_req != stall_ack && (acc_addr.size() - a0) == stall_at && bus.ddr_read) begin
                bus.ddr_waitrequest = 1'b1;
                stall_left = stall_len - 1;
                stall_ack  = stall_req;
            end else begin
                bus.ddr_waitrequest = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.write = 1'b1; bus.addr = a; bus.writedata = d;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus.read = 1'b1; bus.addr = a;
        @(negedge clk);
        bus.read = 1'b0;
        chk(tag, bus.readdata, exp);
    endtask

    task automatic wait_got(input string tag, input int n);
        int k = 0;
        while (got.size() < n && k < 500) begin @(negedge clk); k++; end
        chk(tag, got.size(), n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls, maxo, o;
        bus.write = 1'b0; bus.read = 1'b0; bus.addr = '0; bus.writedata = '0; bus.ready = 1'b1;

        // Reset state
        @(negedge clk); #1;
        chk("rst_ddr_read", bus.ddr_read, 0);
        chk("rst_ddr_addr", bus.ddr_addr, 0);
        chk("rst_v", bus.v, 0);
        chk("rst_d_out", {16'd0, bus.d_out}, 0);
        chk("rst_readdata", bus.readdata, 0);
        @(negedge clk); rst = 1'b1;
        rd_chk("rst_base", 3'd0, 0);
        rd_chk("rst_len", 3'd1, 0);
        rd_chk("rst_step", 3'd2, 1);
        rd_chk("rst_delivered", 3'd3, 0);
        rd_chk("rst_done", 3'd5, 0);
        rd_chk("unmapped_7", 3'd7, 32'hdeadbeef);
        rd_chk("unmapped_4", 3'd4, 32'hdeadbeef);

        // Basic run
        csr_wr(3'd0, 32'h100); csr_wr(3'd1, 4); csr_wr(3'd2, 1);
        a0 = acc_addr.size(); g0 = got.size();
        csr_wr(3'd4, 0); #1;
        chk("basic_first_read", bus.ddr_read, 1);
        chk("basic_first_addr", bus.ddr_addr, 32'h100);
        wait_got("basic_count", g0 + 4);
        chk("basic_d0", got[g0+0], 16'h1111);
        chk("basic_d1", got[g0+1], 16'h2222);
        chk("basic_d2", got[g0+2], 16'h3333);
        chk("basic_d3", got[g0+3], 16'h4444);
        repeat (4) @(negedge clk);
        chk("basic_nreq", acc_addr.size() - a0, 4);
        for (int i = 0; i < 4; i++) chk("basic_addr", acc_addr[a0+i], 32'h100 + i);
        rd_chk("basic_done", 3'd5, 1);
        rd_chk("basic_delivered", 3'd3, 4);

        // Waitrequest stall on the second request
        a0 = acc_addr.size(); g0 = got.size();
        stall_at = 1; stall_len = 3; stall_req++;
        csr_wr(3'd4, 0);
        stalls = 0;
        for (int k = 0; k < 60 && got.size() < g0 + 4; k++) begin
            @(negedge clk); #1;
            if (bus.ddr_waitrequest) begin
                stalls++;
                chk("stall_addr_hold", bus.ddr_addr, 32'h101);
                chk("stall_read_hold", bus.ddr_read, 1);
            end
        end
        chk("stall_cycles", stalls, 3);
        chk("stall_count", got.size() - g0, 4);
        repeat (4) @(negedge clk);
        chk("stall_nreq", acc_addr.size() - a0, 4);
        for (int i = 0; i < 4; i++) chk("stall_addr", acc_addr[a0+i], 32'h100 + i);
        for (int i = 0; i < 4; i++) chk("stall_data", got[g0+i], mem_f(32'h100 + i));

        // Backpressure: 16 samples, sink stalled for 30 cycles
        csr_wr(3'd0, 32'h200); csr_wr(3'd1, 16);
        @(negedge clk); bus.ready = 1'b0;
        a0 = acc_addr.size(); g0 = got.size();
        csr_wr(3'd4, 0);
        maxo = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); #1;
            o = (acc_addr.size() - a0) - (got.size() - g0);
            if (o > maxo) maxo = o;
        end
        chk("bp_max_outstanding", maxo, DEPTH);
        chk("bp_nreq_stalled", acc_addr.size() - a0, 8);
        chk("bp_read_dropped", bus.ddr_read, 0);
        chk("bp_v_held", bus.v, 1);
        chk("bp_head", {16'd0, bus.d_out}, 16'h1111);
        bus.ready = 1'b1;
        wait_got("bp_count", g0 + 16);
        for (int i = 0; i < 16; i++) chk("bp_data", got[g0+i], mem_f(32'h200 + i));
        for (int i = 0; i < 16; i++) chk("bp_addr", acc_addr[a0+i], 32'h200 + i);

        // Zero length
        repeat (4) @(negedge clk);
        csr_wr(3'd6, 0);
        rd_chk("zl_done_cleared", 3'd5, 0);
        rd_chk("zl_delivered_cleared", 3'd3, 0);
        csr_wr(3'd1, 0);
        a0 = acc_addr.size();
        csr_wr(3'd4, 0); #1;
        chk("zl_no_read", bus.ddr_read, 0);
        rd_chk("zl_done", 3'd5, 1);
        repeat (4) @(negedge clk);
        chk("zl_nreq", acc_addr.size() - a0, 0);

        // Step 0: same address three times
        csr_wr(3'd0, 32'h300); csr_wr(3'd1, 3); csr_wr(3'd2, 0);
        a0 = acc_addr.size(); g0 = got.size();
        csr_wr(3'd4, 0);
        wait_got("s0_count", g0 + 3);
        repeat (4) @(negedge clk);
        chk("s0_nreq", acc_addr.size() - a0, 3);
        for (int i = 0; i < 3; i++) chk("s0_addr", acc_addr[a0+i], 32'h300);
        for (int i = 0; i < 3; i++) chk("s0_data", got[g0+i], 16'h1111);

        // Mid-run soft reset with exactly 2 reads outstanding
        csr_wr(3'd0, 32'h400); csr_wr(3'd1, 8); csr_wr(3'd2, 1);
        lat = 6;
        a0 = acc_addr.size(); g0 = got.size();
        stall_at = 2; stall_len = 5; stall_req++;
        csr_wr(3'd4, 0);
        for (int k = 0; k < 40 && (acc_addr.size() - a0) < 2; k++) begin @(negedge clk); #1; end
        chk("sr_two_pending", acc_addr.size() - a0, 2);
        bus.addr = 3'd6; bus.writedata = 0; bus.write = 1'b1;
        @(negedge clk); bus.write = 1'b0; #1;
        chk("sr_read_off", bus.ddr_read, 0);
        chk("sr_v_off", bus.v, 0);
        csr_wr(3'd4, 0); #1;
        chk("sr_start_ignored", bus.ddr_read, 0);
        repeat (12) @(negedge clk);
        chk("sr_dropped", got.size() - g0, 0);
        chk("sr_nreq", acc_addr.size() - a0, 2);
        rd_chk("sr_done", 3'd5, 0);
        rd_chk("sr_delivered", 3'd3, 0);
        lat = 2;
        a0 = acc_addr.size(); g0 = got.size();
        csr_wr(3'd4, 0);
        wait_got("sr_rerun_count", g0 + 8);
        for (int i = 0; i < 8; i++) chk("sr_rerun_data", got[g0+i], mem_f(32'h400 + i));
        repeat (4) @(negedge clk);
        rd_chk("sr_rerun_done", 3'd5, 1);
        rd_chk("sr_rerun_delivered", 3'd3, 8);

        // Asynchronous reset mid-ISSUE
        csr_wr(3'd0, 32'h500); csr_wr(3'd1, 16); csr_wr(3'd2, 5);
        csr_wr(3'd4, 0);
        repeat (3) @(negedge clk); #1;
        chk("ar_issuing", bus.ddr_read, 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_ddr_read", bus.ddr_read, 0);
        chk("ar_ddr_addr", bus.ddr_addr, 0);
        chk("ar_v", bus.v, 0);
        chk("ar_d_out", {16'd0, bus.d_out}, 0);
        chk("ar_readdata", bus.readdata, 0);
        @(negedge clk); #2 rst = 1'b1;
        rd_chk("ar_step", 3'd2, 1);
        rd_chk("ar_base", 3'd0, 0);
        rd_chk("ar_len", 3'd1, 0);
        rd_chk("ar_done", 3'd5, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
